// File: rtl/prime_pkg.sv
// Shared definitions for the primality sequencer: state encoding and
// control-word layout (a1..a7 packed into bits 0..6).
package prime_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_TEST = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int unsigned A1_B = 0;
    localparam int unsigned A2_B = 1;
    localparam int unsigned A3_B = 2;
    localparam int unsigned A4_B = 3;
    localparam int unsigned A5_B = 4;
    localparam int unsigned A6_B = 5;
    localparam int unsigned A7_B = 6;

    // Holds K, E, C, P; A follows n because the datapath cannot hold A.
    localparam logic [6:0] CTL_NEUTRAL = 7'b1101010;

endpackage

// File: rtl/prime_seq_decode.sv
// Combinational control-word and next-state decode for prime_seq_ctrl.
// PRIME_SEQ_EARLY_EXIT_EN: stop at the first proper divisor found.
module prime_seq_decode
    import prime_pkg::*;
(
    input  state_t      state,
    input  logic [7:0]  a_val,
    input  logic [7:0]  k_val,
    input  logic        n_small,
    output logic [6:0]  ctl,
    output state_t      state_nxt
);

    always_comb begin
        ctl       = CTL_NEUTRAL;
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_INIT: begin
                ctl[A2_B] = 1'b0;
                ctl[A3_B] = 1'b0;
                ctl[A5_B] = 1'b0;
                ctl[A6_B] = 1'b0;
                state_nxt = n_small ? ST_FIN : ST_TEST;
            end
            ST_TEST: begin
                if (k_val == '0) begin
                    state_nxt = ST_FIN;
                end else if (a_val >= k_val) begin
                    ctl[A1_B] = 1'b1;
                end else begin
                    ctl[A2_B] = 1'b0;
                    ctl[A3_B] = 1'b1;
                    ctl[A4_B] = 1'b0;
                    if (a_val == '0) begin
`ifdef PRIME_SEQ_EARLY_EXIT_EN
                        // K=1 always divides, so only a larger K proves compositeness.
                        if (k_val != 8'd1) begin
                            ctl[A2_B] = 1'b1;
                            state_nxt = ST_FIN;
                        end else begin
                            ctl[A6_B] = 1'b0;
                            ctl[A5_B] = 1'b1;
                        end
`else
                        ctl[A6_B] = 1'b0;
                        ctl[A5_B] = 1'b1;
`endif
                    end
                end
            end
            ST_FIN: begin
                ctl[A7_B] = 1'b0;
                state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/prime_seq_ctrl.sv
// Sequencer for the repeated-subtraction primality datapath; sole driver of a1..a7.
// PRIME_SEQ_EARLY_EXIT_EN (in prime_seq_decode) enables early exit on composites.
module prime_seq_ctrl
    import prime_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  n,
    input  logic [7:0]  A,
    input  logic [7:0]  K,
    output logic        a1,
    output logic        a2,
    output logic        a3,
    output logic        a4,
    output logic        a5,
    output logic        a6,
    output logic        a7,
    output logic        busy,
    output logic        done,
    output logic [15:0] cyc_cnt
);

    state_t      state_q, state_d, dec_nxt;
    logic [7:0]  n_q, n_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [6:0]  ctl;

    prime_seq_decode u_decode (
        .state     (state_q),
        .a_val     (A),
        .k_val     (K),
        .n_small   (n_q < 8'd2),
        .ctl       (ctl),
        .state_nxt (dec_nxt)
    );

    always_comb begin
        state_d   = dec_nxt;
        n_d       = n_q;
        cyc_cnt_d = cyc_cnt_q;
        if (state_q == ST_IDLE && start) begin
            state_d   = ST_INIT;
            n_d       = n;
            cyc_cnt_d = '0;
        end
        if (state_q == ST_TEST && cyc_cnt_q != '1)
            cyc_cnt_d = cyc_cnt_q + 16'd1;
        busy_d = (state_d == ST_INIT) || (state_d == ST_TEST) || (state_d == ST_FIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            cyc_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cyc_cnt_q <= cyc_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign a1      = ctl[A1_B];
    assign a2      = ctl[A2_B];
    assign a3      = ctl[A3_B];
    assign a4      = ctl[A4_B];
    assign a5      = ctl[A5_B];
    assign a6      = ctl[A6_B];
    assign a7      = ctl[A7_B];
    assign busy    = busy_q;
    assign done    = done_q;
    assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_prime_seq_ctrl.sv
// Directed bench for prime_seq_ctrl driving a behavioural model of the datapath.
module tb_prime_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  n_in;
    logic [7:0]  dp_a, dp_k, dp_e, dp_c;
    logic        dp_p;
    logic        a1, a2, a3, a4, a5, a6, a7;
    logic        busy, done;
    logic [15:0] cyc_cnt;
    logic [6:0]  ctl_obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prime_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n       (n_in),
        .A       (dp_a),
        .K       (dp_k),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .a4      (a4),
        .a5      (a5),
        .a6      (a6),
        .a7      (a7),
        .busy    (busy),
        .done    (done),
        .cyc_cnt (cyc_cnt)
    );

    assign ctl_obs = {a7, a6, a5, a4, a3, a2, a1};

    // Datapath model: registers A, K, E, C, P steered by the select lines.
    always @(posedge clk) begin
        dp_a <= a1 ? dp_a - dp_k : n_in;
        dp_k <= a2 ? dp_k : (a3 ? dp_k - 8'd1 : n_in - 8'd1);
        dp_e <= a4 ? dp_e : dp_a;
        dp_c <= a6 ? dp_c : (a5 ? dp_c + 8'd1 : 8'd1);
        dp_p <= a7 ? dp_p : (dp_c == 8'd2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one run and checks done timing and the final results.
    task automatic run(input string tag, input logic [7:0] nv, input int exp_edges,
                       input logic [15:0] exp_cyc, input logic exp_p, input logic [7:0] exp_c,
                       input bit hold_start, output bit sub_seen);
        int edges;
        sub_seen = 1'b0;
        @(negedge clk);
        n_in  = nv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        check({tag, "_busy_init"}, {31'd0, busy}, 32'd1);
        edges = 0;
        while (!done && edges < 3000) begin
            @(posedge clk);
            #1;
            edges++;
            if (a1) sub_seen = 1'b1;
        end
        check({tag, "_done_edge"}, edges, exp_edges);
        check({tag, "_cyc_cnt"}, {16'd0, cyc_cnt}, {16'd0, exp_cyc});
        check({tag, "_P"}, {31'd0, dp_p}, {31'd0, exp_p});
        check({tag, "_C"}, {24'd0, dp_c}, {24'd0, exp_c});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit sub;
        rst   = 1'b1;
        start = 1'b0;
        n_in  = 8'd0;
        #12;
        check("rst_ctl", {25'd0, ctl_obs}, {25'd0, 7'b1101010});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cyc", {16'd0, cyc_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("n2", 8'd2, 6, 16'd4, 1'b1, 8'd2, 1'b0, sub);

        run("n7", 8'd7, 24, 16'd22, 1'b1, 8'd2, 1'b0, sub);
        check("n7_E", {24'd0, dp_e}, 32'd0);

`ifdef PRIME_SEQ_EARLY_EXIT_EN
        run("n4", 8'd4, 7, 16'd5, 1'b0, 8'd1, 1'b0, sub);
`else
        run("n4", 8'd4, 13, 16'd11, 1'b0, 8'd3, 1'b0, sub);
`endif

        run("n0", 8'd0, 2, 16'd0, 1'b0, 8'd1, 1'b0, sub);
        check("n0_no_sub", {31'd0, sub}, 32'd0);
        run("n1", 8'd1, 2, 16'd0, 1'b0, 8'd1, 1'b0, sub);
        check("n1_no_sub", {31'd0, sub}, 32'd0);

        // n=9 aborted by reset in its fifth TEST cycle.
        @(negedge clk);
        n_in  = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("n9_busy_mid", {31'd0, busy}, 32'd1);
        check("n9_cyc_mid", {16'd0, cyc_cnt}, 32'd4);
        rst = 1'b1;
        #1;
        check("n9_rst_ctl", {25'd0, ctl_obs}, {25'd0, 7'b1101010});
        check("n9_rst_busy", {31'd0, busy}, 32'd0);
        check("n9_rst_done", {31'd0, done}, 32'd0);
        check("n9_rst_cyc", {16'd0, cyc_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("n9_idle_after_rst", {31'd0, busy}, 32'd0);
        run("n3", 8'd3, 9, 16'd7, 1'b1, 8'd2, 1'b0, sub);

        // start held high: one run, then the next begins only from IDLE.
        run("n5", 8'd5, 16, 16'd14, 1'b1, 8'd2, 1'b1, sub);
        @(posedge clk);
        #1;
        check("n5_restart_busy", {31'd0, busy}, 32'd1);
        check("n5_restart_cyc", {16'd0, cyc_cnt}, 32'd0);
        start = 1'b0;
        begin
            int guard = 0;
            while (!done && guard < 3000) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("n5_restart_done", {31'd0, done}, 32'd1);
            check("n5_restart_cyc_end", {16'd0, cyc_cnt}, 32'd14);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        check("n5_stays_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
